// File: rtl/pwm_avalon_pkg.sv
// Shared definitions for the multi-channel Avalon PWM block.
// Holds the word-address map, CTRL/STATUS bit positions and the
// address decoder used by the top level.
package pwm_avalon_pkg;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_PERIOD = 1;
  localparam int unsigned ADDR_PRESC  = 2;
  localparam int unsigned ADDR_STATUS = 3;
  localparam int unsigned ADDR_DUTY0  = 4;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_INV   = 1;
  localparam int unsigned CTRL_IRQEN = 2;
  localparam int unsigned CTRL_W     = 3;

  localparam int unsigned STATUS_WRAP = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_PERIOD,
    SEL_PRESC,
    SEL_STATUS,
    SEL_DUTY
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input int unsigned addr,
                                           input int unsigned num_ch);
    if (addr == ADDR_CTRL)        return SEL_CTRL;
    else if (addr == ADDR_PERIOD) return SEL_PERIOD;
    else if (addr == ADDR_PRESC)  return SEL_PRESC;
    else if (addr == ADDR_STATUS) return SEL_STATUS;
    else if (addr >= ADDR_DUTY0 && addr < ADDR_DUTY0 + num_ch) return SEL_DUTY;
    else return SEL_NONE;
  endfunction

endpackage

// File: rtl/pwm_avalon_multi_cmp.sv
// One PWM channel: live DUTY register, its period-boundary shadow,
// the duty compare and the registered, polarity-adjusted output.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   duty_we_i        write strobe for this channel's DUTY register
//   duty_wdata_i     DUTY write data
//   load_shadow_i    copy DUTY into the shadow (wrap event or disabled)
//   per_cnt_i        shared period counter
//   enable_i         CTRL.enable
//   invert_i         CTRL.invert
//   pwm_o            registered PWM output
//   duty_rd_o        live DUTY value for readback
module pwm_channel_cmp #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             duty_we_i,
  input  logic [CNT_W-1:0] duty_wdata_i,
  input  logic             load_shadow_i,
  input  logic [CNT_W-1:0] per_cnt_i,
  input  logic             enable_i,
  input  logic             invert_i,
  output logic             pwm_o,
  output logic [CNT_W-1:0] duty_rd_o
);

  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] duty_shadow_q, duty_shadow_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    duty_d        = duty_we_i ? duty_wdata_i : duty_q;
    // Shadow takes the pre-write DUTY, so a same-cycle write waits a period.
    duty_shadow_d = load_shadow_i ? duty_q : duty_shadow_q;
    // Disabled channels sit at the inactive level regardless of the compare.
    pwm_d         = enable_i ? ((per_cnt_i < duty_shadow_q) ^ invert_i) : invert_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q        <= '0;
      duty_shadow_q <= '0;
      pwm_q         <= 1'b0;
    end else begin
      duty_q        <= duty_d;
      duty_shadow_q <= duty_shadow_d;
      pwm_q         <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign duty_rd_o = duty_q;

endmodule

// File: rtl/pwm_avalon_multi.sv
// Multi-channel PWM generator with an Avalon-MM slave register port.
// A prescaler and a shared period counter drive NUM_CH duty comparators;
// PERIOD and DUTY are double-buffered and take effect at period wrap.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address        Avalon word address
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       combinational, zero-extended read data
//   pwm_out        registered PWM outputs, bit n = channel n
//   irq            STATUS.wrap & CTRL.irq_en
module pwm_avalon_multi
  import pwm_avalon_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  logic              wr_en;
  reg_sel_e          sel;
  logic [NUM_CH-1:0] duty_hit;
  logic [CNT_W-1:0]  duty_rd [NUM_CH];

  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               wrap_q, wrap_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]   per_shadow_q, per_shadow_d;

  logic enable, tick, wrap_ev, load_shadow;
  logic unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign sel          = decode_addr(32'(address), NUM_CH);
  assign unused_wdata = ^writedata;

  assign enable      = ctrl_q[CTRL_EN];
  assign tick        = enable && (presc_cnt_q == presc_q);
  assign wrap_ev     = tick && (per_cnt_q == per_shadow_q);
  assign load_shadow = wrap_ev | ~enable;

  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    presc_d  = presc_q;
    if (wr_en) begin
      case (sel)
        SEL_CTRL:   ctrl_d   = writedata[CTRL_W-1:0];
        SEL_PERIOD: period_d = writedata[CNT_W-1:0];
        SEL_PRESC:  presc_d  = writedata[PRESC_W-1:0];
        default: ;
      endcase
    end
    // Set beats write-1-clear when both land on the same cycle.
    wrap_d = wrap_ev |
             (wrap_q & ~(wr_en && (sel == SEL_STATUS) && writedata[STATUS_WRAP]));
    per_shadow_d = load_shadow ? period_q : per_shadow_q;
  end

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    per_cnt_d   = per_cnt_q;
    if (!enable) begin
      presc_cnt_d = '0;
      per_cnt_d   = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
      per_cnt_d   = wrap_ev ? '0 : per_cnt_q + 1'b1;
    end else begin
      presc_cnt_d = presc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q       <= '0;
      period_q     <= '0;
      presc_q      <= '0;
      wrap_q       <= 1'b0;
      presc_cnt_q  <= '0;
      per_cnt_q    <= '0;
      per_shadow_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      period_q     <= period_d;
      presc_q      <= presc_d;
      wrap_q       <= wrap_d;
      presc_cnt_q  <= presc_cnt_d;
      per_cnt_q    <= per_cnt_d;
      per_shadow_q <= per_shadow_d;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign duty_hit[n] = (sel == SEL_DUTY) && (32'(address) == ADDR_DUTY0 + n);

    pwm_channel_cmp #(.CNT_W(CNT_W)) u_cmp (
      .clk          (clk),
      .reset_n      (reset_n),
      .duty_we_i    (wr_en & duty_hit[n]),
      .duty_wdata_i (writedata[CNT_W-1:0]),
      .load_shadow_i(load_shadow),
      .per_cnt_i    (per_cnt_q),
      .enable_i     (enable),
      .invert_i     (ctrl_q[CTRL_INV]),
      .pwm_o        (pwm_out[n]),
      .duty_rd_o    (duty_rd[n])
    );
  end

  always_comb begin
    readdata = '0;
    case (sel)
      SEL_CTRL:   readdata[CTRL_W-1:0]  = ctrl_q;
      SEL_PERIOD: readdata[CNT_W-1:0]   = period_q;
      SEL_PRESC:  readdata[PRESC_W-1:0] = presc_q;
      SEL_STATUS: readdata[STATUS_WRAP] = wrap_q;
      SEL_DUTY: begin
        for (int unsigned n = 0; n < NUM_CH; n++)
          if (duty_hit[n]) readdata[CNT_W-1:0] = duty_rd[n];
      end
      default: ;
    endcase
  end

  assign irq = wrap_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_pwm_avalon_multi.sv
module tb_pwm_avalon_multi;
  localparam int NCH = 3;
  localparam int AW  = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [AW-1:0]  address = '0;
  logic           chipselect = 1'b0;
  logic           write_n = 1'b1;
  logic [31:0]    writedata = '0;
  logic [31:0]    readdata;
  logic [NCH-1:0] pwm_out;
  logic           irq;

  always #5 clk = ~clk;

  pwm_avalon_multi #(.NUM_CH(NCH), .CNT_W(16), .PRESC_W(16), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pwm_out(pwm_out), .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time inside the current period is tracked as a plain
  // clock count; the counter value is that count divided by the prescale.
  logic [2:0]     m_ctrl;
  logic [15:0]    m_period, m_presc, m_psh;
  logic           m_wrap;
  int             m_phase;
  logic [15:0]    m_duty [NCH];
  logic [15:0]    m_dsh  [NCH];
  logic [NCH-1:0] m_pwm;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ctrl <= '0; m_period <= '0; m_presc <= '0; m_psh <= '0;
      m_wrap <= 1'b0; m_phase <= 0; m_pwm <= '0;
      for (int n = 0; n < NCH; n++) begin m_duty[n] <= '0; m_dsh[n] <= '0; end
    end else begin
      bit en, wr, wev;
      int plen, cnt;
      en   = m_ctrl[0];
      wr   = chipselect && !write_n;
      plen = (int'(m_psh) + 1) * (int'(m_presc) + 1);
      cnt  = m_phase / (int'(m_presc) + 1);
      wev  = en && (m_phase == plen - 1);
      for (int n = 0; n < NCH; n++)
        m_pwm[n] <= en ? ((cnt < int'(m_dsh[n])) ^ m_ctrl[1]) : m_ctrl[1];
      m_phase <= (!en || wev) ? 0 : m_phase + 1;
      if (!en || wev) begin
        m_psh <= m_period;
        for (int n = 0; n < NCH; n++) m_dsh[n] <= m_duty[n];
      end
      m_wrap <= wev || (m_wrap && !(wr && address == 3 && writedata[0]));
      if (wr) begin
        case (int'(address))
          0: m_ctrl   <= writedata[2:0];
          1: m_period <= writedata[15:0];
          2: m_presc  <= writedata[15:0];
          4, 5, 6: m_duty[int'(address) - 4] <= writedata[15:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0: return {29'b0, m_ctrl};
      1: return {16'b0, m_period};
      2: return {16'b0, m_presc};
      3: return {31'b0, m_wrap};
      4, 5, 6: return {16'b0, m_duty[a - 4]};
      default: return 32'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    check("pwm_out", 64'(pwm_out), 64'(m_pwm));
    check("irq", 64'(irq), 64'(m_wrap & m_ctrl[2]));
    check("readdata", 64'(readdata), 64'(m_read(int'(address))));
  end

  task automatic wr(input int a, input logic [31:0] d);
    address = AW'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string name);
    address = AW'(a); #1;
    check(name, 64'(readdata), 64'(exp));
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin @(negedge clk); hi += int'(pwm_out[ch]); end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    #1;
    check("reset_pwm", 64'(pwm_out), 0);
    check("reset_irq", 64'(irq), 0);
    for (int a = 0; a < 8; a++) rd(a, 32'h0, "reset_read");
    @(negedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #2;

    // Basic duty: 3 of 10 high, wrap after first period
    wr(2, 0); wr(1, 9); wr(4, 3); wr(0, 1);
    rd(3, 0, "status_before_wrap");
    count_high(0, 1, hi);
    count_high(0, 20, hi); check("basic_high_20", hi, 6);
    rd(3, 1, "status_after_wrap");

    // Edge duties and inversion
    wr(5, 0); wr(6, 10);
    idle(12);
    count_high(1, 50, hi); check("duty0_const_low", hi, 0);
    count_high(2, 50, hi); check("duty_full_const_high", hi, 50);
    wr(0, 3);
    count_high(1, 1, hi);
    count_high(1, 30, hi); check("inv_duty0_high", hi, 30);
    count_high(2, 30, hi); check("inv_full_low", hi, 0);

    // Prescaler and readback
    wr(0, 0); wr(2, 32'hABCD_0004); wr(1, 3); wr(4, 2); wr(0, 1);
    count_high(0, 1, hi);
    count_high(0, 40, hi); check("presc_high_40", hi, 20);
    rd(2, 4, "rd_presc"); rd(1, 3, "rd_period"); rd(4, 2, "rd_duty0");
    wr(7, 32'hFFFF_FFFF);
    rd(7, 0, "rd_unmapped");

    // Double buffering
    wr(0, 0); wr(2, 0); wr(1, 9); wr(4, 3); wr(0, 1);
    idle(4);
    wr(4, 7); wr(1, 4);
    rd(1, 4, "period_live"); rd(4, 7, "duty_live");
    count_high(0, 1, hi);
    count_high(0, 4, hi);  check("old_period_tail_low", hi, 0);
    count_high(0, 10, hi); check("new_period_clamped", hi, 10);

    // Status and irq
    wr(0, 0); wr(2, 0); wr(1, 9); wr(4, 3); wr(3, 1); wr(0, 5);
    idle(11);
    check("irq_after_wrap", 64'(irq), 1);
    wr(3, 1);
    check("irq_cleared", 64'(irq), 0);
    rd(3, 0, "status_cleared");
    idle(7);
    wr(3, 1);
    rd(3, 1, "wrap_set_wins");
    check("irq_set_wins", 64'(irq), 1);

    // Disable, re-enable, asynchronous reset
    wr(0, 7); idle(3);
    wr(0, 6); idle(1);
    check("disable_inactive", 64'(pwm_out), 64'(3'b111));
    wr(0, 7);
    count_high(0, 1, hi);
    count_high(0, 3, hi); check("reenable_first_low", hi, 0);
    count_high(0, 7, hi); check("reenable_rest_high", hi, 7);
    idle(4); #1;
    reset_n = 1'b0; #1;
    check("async_reset_pwm", 64'(pwm_out), 0);
    check("async_reset_irq", 64'(irq), 0);
    for (int a = 0; a < 8; a++) rd(a, 32'h0, "async_reset_read");
    @(posedge clk); #3 reset_n = 1'b1;
    idle(2);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: wr(4 + int'($urandom_range(0, NCH - 1)), ($urandom & 32'hFFFF_0000) | $urandom_range(0, 20));
        1: wr(1, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 15));
        2: wr(0, $urandom);
        3: wr(3, $urandom);
        4: idle(int'($urandom_range(1, 30)));
        5: begin
          wr(0, $urandom & 32'hFFFF_FFFE);
          wr(2, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3));
        end
        6: begin
          address = AW'($urandom_range(0, 7)); writedata = $urandom;
          chipselect = 1'b1; write_n = 1'b1;
          @(posedge clk); #2;
          chipselect = 1'b0;
        end
        default: wr(7, $urandom);
      endcase
    end
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_avalon_multi.md
Name: pwm_avalon_multi

Overview:
Multi-channel, parametrised PWM generator with an Avalon-MM slave register interface. It succeeds the single 8-bit PWM control output register. A programmable prescaler and a shared period counter drive NUM_CH independent duty comparators. Duty and period writes are double-buffered, so they take effect only at period boundaries. The block sits on the processor's Avalon bus and drives motor/LED PWM pins directly.

Parameters:
NUM_CH, 4, number of PWM output channels (1..8)
CNT_W, 16, width of the period counter, PERIOD register and DUTY registers
PRESC_W, 16, width of the prescaler counter and PRESCALE register
ADDR_W, 3, Avalon word-address width; must satisfy 2^ADDR_W >= 4+NUM_CH

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
address  in  ADDR_W  Avalon word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data; combinational, zero wait states, zero-extended
pwm_out  out  NUM_CH  registered PWM outputs, bit n = channel n
irq  out  1  level interrupt = STATUS.wrap & CTRL.irq_en

Behaviour:
- Register map (word addresses):
  - 0 CTRL: bit0 enable, bit1 invert (output polarity), bit2 irq_en.
  - 1 PERIOD [CNT_W-1:0].
  - 2 PRESCALE [PRESC_W-1:0].
  - 3 STATUS: bit0 wrap, sticky; writing 1 clears it.
  - 4+n DUTY[n] [CNT_W-1:0].
  - Unmapped addresses read 0; writes to them are ignored.
- Write: occurs when chipselect & ~write_n. Upper writedata bits beyond each field width are discarded. All registers read back their live (unshadowed) value.
- Reset values: all registers 0, all counters 0, pwm_out = 0, irq = 0.
- Prescaler: presc_cnt counts 0..PRESCALE. tick = (presc_cnt == PRESCALE), after which presc_cnt returns to 0. PRESCALE=0 gives a tick every clk.
- Period counter: on tick, per_cnt increments. When per_cnt == per_shadow and tick, per_cnt wraps to 0 and the wrap event fires. Period length = (PERIOD+1)*(PRESCALE+1) clks.
- Shadow registers: on the wrap event, and on every cycle while enable=0, per_shadow <= PERIOD and duty_shadow[n] <= DUTY[n]. A write in the same cycle as a wrap is not captured by that wrap; it is captured at the next one.
- Compare: raw[n] = (per_cnt < duty_shadow[n]).
  - DUTY=0 gives constant low.
  - DUTY >= PERIOD+1 gives constant high; no wrap-around glitch.
  - Compare is unsigned at CNT_W width.
- Output: pwm_out[n] <= raw[n] ^ invert, registered, so 1 clk latency from per_cnt.
- Disable: while enable=0, presc_cnt and per_cnt are held at 0, no wrap events occur, and pwm_out = {NUM_CH{invert}} (inactive level, registered).
- Enable 0->1: counting starts with per_cnt=0 using the shadows loaded on the previous cycle. The first pwm_out edge appears 1 clk after enable is registered.
- Enable 1->0 mid-period: counters clear on the next clk; outputs go inactive 1 clk later. Register contents are preserved.
- STATUS.wrap: set on every wrap event. A write-1-clear and a wrap in the same cycle leaves wrap=1 (set wins).
- PERIOD reduced below the current per_cnt: no effect until the next wrap, because the compare uses per_shadow.
- Asynchronous reset mid-operation returns everything to reset values immediately. pwm_out = 0 regardless of the previous invert setting.

Decomposition:
- Package pwm_avalon_pkg holds:
  - address constants ADDR_CTRL=0, ADDR_PERIOD=1, ADDR_PRESC=2, ADDR_STATUS=3, ADDR_DUTY0=4;
  - CTRL bit indices CTRL_EN=0, CTRL_INV=1, CTRL_IRQEN=2;
  - STATUS_WRAP=0.
- Sub-module pwm_channel_cmp, instantiated NUM_CH times via generate, contains:
  - the DUTY live register and duty_shadow;
  - the compare, invert and output flop;
  - ports: clk, reset_n, duty write strobe/data, load_shadow, per_cnt, enable, invert, pwm_out bit, duty readback.
- Top level keeps the bus decode, CTRL/PERIOD/PRESCALE/STATUS, prescaler, period counter and readdata mux.

Test Plan:
1. Basic duty: PRESCALE=0, PERIOD=9, DUTY0=3, CTRL=1 -> pwm_out[0] high 3 clk, low 7 clk, repeating. STATUS.wrap sets after the first 10-clk period.
2. Edge duties: DUTY1=0, DUTY2=10, DUTY3=200 with PERIOD=9 -> ch1 constant 0, ch2 and ch3 constant 1 across 5 periods; set CTRL=3 (invert) -> all levels flip.
3. Prescaler: PRESCALE=4, PERIOD=3, DUTY0=2 -> period 20 clk, ch0 high 10 clk; readback of PRESCALE=4, PERIOD=3, DUTY0=2; read of address 7 with NUM_CH=3 -> 0.
4. Double-buffering: mid-period write DUTY0 3->7 and PERIOD 9->4 -> current period unchanged (high 3 of 10); next period high 5 of 5, i.e. duty clamps to 100%.
5. Status/irq: CTRL=5, wait for wrap -> irq=1. Write STATUS=1 in a non-wrap cycle -> irq=0 next clk. Write STATUS=1 in the exact wrap cycle -> wrap stays 1.
6. Disable and reset: clear enable mid-period -> pwm_out = invert level after 1 clk, counters 0. Re-enable -> full first period from count 0. Assert reset_n mid-period -> pwm_out=0, irq=0 and all registers read 0 immediately.
